// File: rtl/sram_bridge_pkg.sv
// Shared FSM state and access-size encodings for the SRAM-like bus bridge.
package sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sram_like_bridge.sv
// Bridge from the CPU single-cycle SRAM port to the req/addr_ok/data_ok bus.
// Define SRAM_BRIDGE_PERF_EN to add the perf_stall_cnt stall-cycle counter.
module sram_like_bridge
  import sram_bridge_pkg::*;
#(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned PERF_W = 32,
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [BE_W-1:0]   cpu_wen,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              cpu_hold,
  input  logic              cpu_flush,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
`ifdef SRAM_BRIDGE_PERF_EN
  output logic [PERF_W-1:0] perf_stall_cnt,
`endif
  input  logic [DATA_W-1:0] rdata
);

  state_e              state_q,   state_d;
  logic                req_q,     req_d;
  logic                wr_q,      wr_d;
  logic [1:0]          size_q,    size_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic [DATA_W-1:0]   rbuf_q,    rbuf_d;
  logic                discard_q, discard_d;
  logic                resolve_c;
  logic                drop_c;

  // Next-state: capture in IDLE, hold req until addr_ok, resolve on data_ok.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    discard_d = discard_q;
    resolve_c = 1'b0;
    drop_c    = discard_q | cpu_flush;

    unique case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (cpu_en && !cpu_flush) begin
          state_d = REQ;
          req_d   = 1'b1;
          wr_d    = |cpu_wen;
          size_d  = cpu_size;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
        end
      end
      REQ: begin
        if (cpu_flush) begin
          discard_d = 1'b1;
        end
        if (addr_ok) begin
          req_d = 1'b0;
          if (data_ok) begin
            resolve_c = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cpu_flush) begin
          discard_d = 1'b1;
        end
        if (data_ok) begin
          resolve_c = 1'b1;
        end
      end
      DONE: begin
        if (cpu_flush || !cpu_hold) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flushed access still drains the bus, but its response never reaches the CPU.
    if (resolve_c) begin
      if (drop_c) begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end else begin
        state_d = DONE;
        if (!wr_q) begin
          rbuf_d = rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      discard_q <= discard_d;
    end
  end

  assign req       = req_q;
  assign wr        = wr_q;
  assign size      = size_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign cpu_rdata = rbuf_q;
  assign cpu_stall = cpu_en & (state_q != DONE);

`ifdef SRAM_BRIDGE_PERF_EN
  sat_counter #(
    .W (PERF_W)
  ) u_perf_stall (
    .clk   (clk),
    .rst   (rst),
    .inc_i (cpu_stall),
    .cnt_o (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_sram_like_bridge.sv
// Self-checking bench for sram_like_bridge: directed scenarios plus randomized transactions.
module tb_sram_like_bridge;
  import sram_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_hold;
  logic        cpu_flush;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
`ifdef SRAM_BRIDGE_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_buf;

  always #5 clk = ~clk;

  sram_like_bridge #(
    .ADDR_W (32),
    .DATA_W (32),
    .PERF_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_en    (cpu_en),
    .cpu_wen   (cpu_wen),
    .cpu_size  (cpu_size),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .cpu_hold  (cpu_hold),
    .cpu_flush (cpu_flush),
    .req       (req),
    .wr        (wr),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
`ifdef SRAM_BRIDGE_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .rdata     (rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if ({req, wr, size, addr, wdata} !== 68'h0) begin errors++; $display("FAIL reset_bus: got %h exp 0", {req, wr, size, addr, wdata}); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", cpu_rdata); end
    cpu_en = 1'b0;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", cpu_stall); end
`ifdef SRAM_BRIDGE_PERF_EN
    checks++; if (perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_perf: got %0d exp 0", perf_stall_cnt); end
`endif
    tick();
  endtask

  task automatic test_min_read();
    cpu_en = 1'b1; cpu_wen = 4'b0; cpu_size = SIZE_W; cpu_addr = 32'h1000; cpu_wdata = $urandom;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL min_read_stall_c0: got %b exp 1", cpu_stall); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL min_read_req_c0: got %b exp 0", req); end
    tick();
    checks++; if ({req, wr, size, addr} !== {1'b1, 1'b0, SIZE_W, 32'h1000}) begin errors++; $display("FAIL min_read_bus_c1: got %h exp %h", {req, wr, size, addr}, {1'b1, 1'b0, SIZE_W, 32'h1000}); end
    addr_ok = 1'b1;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL min_read_stall_c1: got %b exp 1", cpu_stall); end
    tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL min_read_req_c2: got %b exp 0", req); end
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hDEADBEEF;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL min_read_stall_c2: got %b exp 1", cpu_stall); end
    tick();
    data_ok = 1'b0; rdata = $urandom; exp_buf = 32'hDEADBEEF;
    checks++; if (cpu_rdata !== exp_buf) begin errors++; $display("FAIL min_read_rdata_c3: got %h exp %h", cpu_rdata, exp_buf); end
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL min_read_stall_c3: got %b exp 0", cpu_stall); end
    cpu_en = 1'b0;
    tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL min_read_req_c4: got %b exp 0", req); end
`ifdef SRAM_BRIDGE_PERF_EN
    checks++; if (perf_stall_cnt !== 32'd3) begin errors++; $display("FAIL min_read_perf: got %0d exp 3", perf_stall_cnt); end
`endif
  endtask

  task automatic test_write_delay();
    logic [31:0] a;
    a = $urandom;
    cpu_en = 1'b1; cpu_wen = 4'b0011; cpu_size = SIZE_H; cpu_addr = a; cpu_wdata = 32'h1234;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL wr_stall_c0: got %b exp 1", cpu_stall); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if ({req, wr, size, addr, wdata} !== {1'b1, 1'b1, SIZE_H, a, 32'h1234}) begin errors++; $display("FAIL wr_bus_stable c%0d: got %h exp %h", c, {req, wr, size, addr, wdata}, {1'b1, 1'b1, SIZE_H, a, 32'h1234}); end
      addr_ok = (c == 4); cpu_addr = $urandom; cpu_wdata = $urandom;
      #1;
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL wr_stall c%0d: got %b exp 1", c, cpu_stall); end
    end
    tick();
    addr_ok = 1'b0;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL wr_req_drop: got %b exp 0", req); end
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL wr_stall_wait: got %b exp 1", cpu_stall); end
    tick();
    data_ok = 1'b1; rdata = $urandom;
    tick();
    data_ok = 1'b0;
    checks++; if (cpu_rdata !== exp_buf) begin errors++; $display("FAIL wr_rdata_unchanged: got %h exp %h", cpu_rdata, exp_buf); end
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL wr_done_stall: got %b exp 0", cpu_stall); end
    cpu_en = 1'b0; cpu_wen = 4'b0;
    tick();
  endtask

  task automatic test_hold();
    cpu_en = 1'b1; cpu_wen = 4'b0; cpu_size = SIZE_W; cpu_addr = $urandom;
    tick();
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0BADF00D;
    tick();
    data_ok = 1'b0; exp_buf = 32'h0BADF00D;
    for (int h = 0; h < 4; h++) begin
      cpu_hold = 1'b1; addr_ok = (h == 1); data_ok = (h == 2); rdata = $urandom;
      #1;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL hold_stall h%0d: got %b exp 0", h, cpu_stall); end
      checks++; if (cpu_rdata !== exp_buf) begin errors++; $display("FAIL hold_rdata h%0d: got %h exp %h", h, cpu_rdata, exp_buf); end
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL hold_no_reissue h%0d: got %b exp 0", h, req); end
      tick();
    end
    cpu_hold = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL hold_release_stall: got %b exp 0", cpu_stall); end
    tick();
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL hold_back_to_idle: got %b exp 1", cpu_stall); end
    cpu_en = 1'b0;
    tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL hold_after_req: got %b exp 0", req); end
  endtask

  task automatic test_flush_wait();
    logic [31:0] b;
    b = $urandom;
    cpu_en = 1'b1; cpu_wen = 4'b0; cpu_addr = $urandom;
    tick();
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; cpu_flush = 1'b1;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL flush_stall_wait: got %b exp 1", cpu_stall); end
    tick();
    cpu_flush = 1'b0; cpu_en = 1'b0; data_ok = 1'b1; rdata = 32'hAAAA5555;
    tick();
    data_ok = 1'b0;
    checks++; if (cpu_rdata !== exp_buf) begin errors++; $display("FAIL flush_buf_kept: got %h exp %h", cpu_rdata, exp_buf); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL flush_req: got %b exp 0", req); end
    cpu_en = 1'b1; cpu_addr = b;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL flush_next_stall: got %b exp 1", cpu_stall); end
    tick();
    checks++; if ({req, addr} !== {1'b1, b}) begin errors++; $display("FAIL flush_next_issue: got %h exp %h", {req, addr}, {1'b1, b}); end
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h13579BDF;
    tick();
    data_ok = 1'b0; exp_buf = 32'h13579BDF;
    checks++; if (cpu_rdata !== exp_buf) begin errors++; $display("FAIL flush_next_rdata: got %h exp %h", cpu_rdata, exp_buf); end
    cpu_en = 1'b0;
    tick();
  endtask

  task automatic test_same_cycle();
    cpu_en = 1'b1; cpu_wen = 4'b0; cpu_addr = $urandom;
    tick();
    addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'hCAFEF00D;
    tick();
    addr_ok = 1'b0; data_ok = 1'b0; exp_buf = 32'hCAFEF00D;
    checks++; if (cpu_rdata !== exp_buf) begin errors++; $display("FAIL same_rdata: got %h exp %h", cpu_rdata, exp_buf); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL same_req: got %b exp 0", req); end
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL same_done_stall: got %b exp 0", cpu_stall); end
    cpu_en = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic        rd;
    logic [3:0]  wen;
    logic [31:0] a, wd, bd;
    logic [1:0]  sz;
    int          aok, dok, comp, fl, hold;
    logic        alive;
    for (int t = 0; t < 40; t++) begin
      rd   = 1'($urandom_range(0, 1));
      wen  = rd ? 4'b0 : 4'($urandom_range(1, 15));
      a    = $urandom; wd = $urandom; bd = $urandom;
      sz   = 2'($urandom_range(0, 2));
      aok  = int'($urandom_range(0, 3));
      dok  = int'($urandom_range(0, 3));
      comp = 1 + aok + dok;
      fl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, comp)) : 0;
      hold = int'($urandom_range(0, 2));
      cpu_en = 1'b1; cpu_wen = wen; cpu_size = sz; cpu_addr = a; cpu_wdata = wd;
      cpu_hold = 1'($urandom_range(0, 1));
      #1;
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rnd_issue t%0d: got %b exp 1", t, cpu_stall); end
      for (int c = 1; c <= comp; c++) begin
        tick();
        if (c <= 1 + aok) begin
          checks++; if ({req, wr, size, addr, wdata} !== {1'b1, |wen, sz, a, wd}) begin errors++; $display("FAIL rnd_req t%0d c%0d: got %h exp %h", t, c, {req, wr, size, addr, wdata}, {1'b1, |wen, sz, a, wd}); end
        end else begin
          checks++; if (req !== 1'b0) begin errors++; $display("FAIL rnd_req_drop t%0d c%0d: got %b exp 0", t, c, req); end
        end
        alive     = !(fl != 0 && c > fl);
        addr_ok   = (c == 1 + aok);
        data_ok   = (c == comp);
        rdata     = (c == comp) ? bd : $urandom;
        cpu_flush = (c == fl);
        cpu_en    = alive;
        cpu_addr  = $urandom; cpu_wdata = $urandom;
        #1;
        checks++; if (cpu_stall !== alive) begin errors++; $display("FAIL rnd_busy_stall t%0d c%0d: got %b exp %b", t, c, cpu_stall, alive); end
      end
      tick();
      addr_ok = 1'b0; data_ok = 1'b0; cpu_flush = 1'b0; rdata = $urandom;
      if (fl == 0 && rd) exp_buf = bd;
      checks++; if (cpu_rdata !== exp_buf) begin errors++; $display("FAIL rnd_rdata t%0d: got %h exp %h", t, cpu_rdata, exp_buf); end
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL rnd_end_req t%0d: got %b exp 0", t, req); end
      if (fl == 0) begin
        for (int h = 0; h <= hold; h++) begin
          cpu_en = 1'b1; cpu_hold = (h < hold);
          #1;
          checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rnd_done_stall t%0d h%0d: got %b exp 0", t, h, cpu_stall); end
          checks++; if (cpu_rdata !== exp_buf) begin errors++; $display("FAIL rnd_done_rdata t%0d h%0d: got %h exp %h", t, h, cpu_rdata, exp_buf); end
          tick();
          checks++; if (req !== 1'b0) begin errors++; $display("FAIL rnd_no_reissue t%0d h%0d: got %b exp 0", t, h, req); end
        end
        cpu_hold = 1'b0;
      end
      cpu_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    r = $urandom;
    cpu_en = 1'b1; cpu_wen = 4'b0; cpu_addr = $urandom;
    tick();
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; rst = 1'b1;
    #1;
    exp_buf = 32'h0;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b exp 0", req); end
    checks++; if (cpu_rdata !== exp_buf) begin errors++; $display("FAIL rstmid_rdata: got %h exp 0", cpu_rdata); end
`ifdef SRAM_BRIDGE_PERF_EN
    checks++; if (perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL rstmid_perf: got %0d exp 0", perf_stall_cnt); end
`endif
    cpu_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    data_ok = 1'b1; rdata = $urandom;
    tick();
    data_ok = 1'b0;
    checks++; if (cpu_rdata !== exp_buf) begin errors++; $display("FAIL rstmid_late_data: got %h exp 0", cpu_rdata); end
    cpu_en = 1'b1; cpu_addr = $urandom;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rstmid_idle_stall: got %b exp 1", cpu_stall); end
    tick();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL rstmid_new_req: got %b exp 1", req); end
    addr_ok = 1'b1; data_ok = 1'b1; rdata = r;
    tick();
    addr_ok = 1'b0; data_ok = 1'b0; exp_buf = r;
    checks++; if (cpu_rdata !== exp_buf) begin errors++; $display("FAIL rstmid_new_rdata: got %h exp %h", cpu_rdata, exp_buf); end
    cpu_en = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'b0; cpu_size = 2'd0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    cpu_hold = 1'b0; cpu_flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
    exp_buf = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_min_read();
    test_write_delay();
    test_hold();
    test_flush_wait();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
